// File: rtl/exec_pkg.sv
// exec_pkg: shared constants, opcode map and decode helpers for the execute
// pipeline (execute_stage + exec_alu).
//   DATA_W / REG_AW / IMM_W : default datapath, register-index and immediate widths
//   OP_*                    : 4-bit opcode encodings
//   is_rt_op()              : opcode takes its B operand from Rt instead of the immediate
//   is_imm_logic_op()       : immediate is zero-extended (logical-immediate ops)
package exec_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int IMM_W    = 16;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_SUBI = 4'b0010;
  localparam logic [3:0] OP_LI   = 4'b0011;
  localparam logic [3:0] OP_ANDI = 4'b0100;
  localparam logic [3:0] OP_ORI  = 4'b0101;
  localparam logic [3:0] OP_XORI = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SLLI = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_SRLI = 4'b1011;
  localparam logic [3:0] OP_SRAI = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b1110;
  localparam logic [3:0] OP_MUL  = 4'b1111;

  function automatic logic is_rt_op(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL};
  endfunction

  function automatic logic is_imm_logic_op(input logic [3:0] op);
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational result generation for one execute-pipeline slot.
//   opcode : operation code (exec_pkg OP_*)
//   a      : Rs operand
//   b      : Rt operand or already-extended immediate (selected upstream)
//   result : DATA_W-bit result, modulo 2^DATA_W
//   carry/ovf (EXECUTE_STATUS_FLAGS_EN only): carry-out / not-borrow and signed
//   overflow for add/sub opcodes, 0 for everything else.
module exec_alu #(
  parameter int DATA_W = exec_pkg::DATA_W
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
`ifdef EXECUTE_STATUS_FLAGS_EN
  ,
  output logic              carry,
  output logic              ovf
`endif
);
  import exec_pkg::*;

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W:0]   sum, dif;
  logic [SH_W-1:0]   shamt;

  // dif carry bit is the NOT-borrow of a - b
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} + {1'b0, ~b} + ONE;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADDI, OP_ADD: result = sum[DATA_W-1:0];
      OP_SUBI, OP_SUB: result = dif[DATA_W-1:0];
      OP_LI:           result = b;
      OP_ANDI, OP_AND: result = a & b;
      OP_ORI,  OP_OR:  result = a | b;
      OP_XORI:         result = a ^ b;
      OP_NOT:          result = ~a;
      OP_SLLI:         result = a << shamt;
      OP_SRLI:         result = a >> shamt;
      OP_SRAI:         result = $signed(a) >>> shamt;
      OP_MUL:          result = a * b;
      default:         result = '0;
    endcase
  end

`ifdef EXECUTE_STATUS_FLAGS_EN
  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    case (opcode)
      OP_ADDI, OP_ADD: begin
        carry = sum[DATA_W];
        ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUBI, OP_SUB: begin
        carry = dif[DATA_W];
        ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (dif[DATA_W-1] != a[DATA_W-1]);
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/execute_stage.sv
// execute_stage: three-stage fixed-latency execute pipeline.
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/opcode/rd : issued instruction (in_valid=0 is a bubble)
//   in_rs/rt_data, imm : operands and 16-bit immediate
//   flush              : drop everything in flight plus the instruction presented now
//   wb_result/rd/en    : register-file write port; result/rd hold while wb_en=0
//   inflight_mask      : destinations of writing instructions in S1..S3
//   flags {Z,N,C,V}    : only with EXECUTE_STATUS_FLAGS_EN, updated on wb_en
// S1 latches decoded operands, S2 the ALU result, S3 the write-back triple.
// Only instructions that will actually write (opcode!=NOP, rd!=0) enter the
// valid pipe, so wb_en and the hazard mask come straight off vld_pipe.
module execute_stage #(
  parameter int DATA_W = exec_pkg::DATA_W,
  parameter int REG_AW = exec_pkg::REG_AW,
  parameter int IMM_W  = exec_pkg::IMM_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [3:0]             in_opcode,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic [DATA_W-1:0]      in_rs_data,
  input  logic [DATA_W-1:0]      in_rt_data,
  input  logic [IMM_W-1:0]       in_imm,
  input  logic                   flush,
  output logic [DATA_W-1:0]      wb_result,
  output logic [REG_AW-1:0]      wb_rd,
  output logic                   wb_en,
  output logic [(1<<REG_AW)-1:0] inflight_mask
`ifdef EXECUTE_STATUS_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);
  import exec_pkg::*;

  localparam int STAGES = 3;

  logic                issue_wr;
  logic [STAGES:1]     vld_pipe;
  logic [3:0]          s1_op;
  logic [REG_AW-1:0]   s1_rd, s2_rd;
  logic [DATA_W-1:0]   s1_a, s1_b, s2_res;
  logic [DATA_W-1:0]   imm_ext, opb, alu_res;

  assign imm_ext = is_imm_logic_op(in_opcode) ?
                   {{(DATA_W-IMM_W){1'b0}}, in_imm} :
                   {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign opb     = is_rt_op(in_opcode) ? in_rt_data : imm_ext;

  // R0 writes and NOPs never enter the pipe; flush kills the same-cycle issue
  assign issue_wr = in_valid && !flush && (in_opcode != OP_NOP) && (in_rd != '0);

`ifdef EXECUTE_STATUS_FLAGS_EN
  logic alu_c, alu_v, s2_c, s2_v;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_res),
    .carry  (alu_c),
    .ovf    (alu_v)
  );
`else
  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_res)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1_op     <= OP_NOP;
      s1_rd     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_rd     <= '0;
      s2_res    <= '0;
      wb_result <= '0;
      wb_rd     <= '0;
    end else begin
      vld_pipe <= flush ? '0 : {vld_pipe[STAGES-1:1], issue_wr};
      if (issue_wr) begin
        s1_op <= in_opcode;
        s1_rd <= in_rd;
        s1_a  <= in_rs_data;
        s1_b  <= opb;
      end
      if (vld_pipe[1]) begin
        s2_rd  <= s1_rd;
        s2_res <= alu_res;
      end
      // outputs hold unless a real write-back is being produced
      if (vld_pipe[2] && !flush) begin
        wb_rd     <= s2_rd;
        wb_result <= s2_res;
      end
    end
  end

`ifdef EXECUTE_STATUS_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_c  <= 1'b0;
      s2_v  <= 1'b0;
      flags <= 4'b0000;
    end else begin
      if (vld_pipe[1]) begin
        s2_c <= alu_c;
        s2_v <= alu_v;
      end
      if (vld_pipe[2] && !flush)
        flags <= {s2_res == '0, s2_res[DATA_W-1], s2_c, s2_v};
    end
  end
`endif

  assign wb_en = vld_pipe[STAGES];

  always_comb begin
    inflight_mask = '0;
    if (vld_pipe[1]) inflight_mask[s1_rd] = 1'b1;
    if (vld_pipe[2]) inflight_mask[s2_rd] = 1'b1;
    if (vld_pipe[3]) inflight_mask[wb_rd] = 1'b1;
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed + randomized check of execute_stage against a
// queue-based in-flight model (age counter per issued instruction).
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_opcode = '0;
  logic [3:0]  in_rd = '0;
  logic [31:0] in_rs_data = '0;
  logic [31:0] in_rt_data = '0;
  logic [15:0] in_imm = '0;
  logic        flush = 1'b0;
  logic [31:0] wb_result;
  logic [3:0]  wb_rd;
  logic        wb_en;
  logic [15:0] inflight_mask;
`ifdef EXECUTE_STATUS_FLAGS_EN
  logic [3:0]  flags;
`endif

  execute_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_opcode     (in_opcode),
    .in_rd         (in_rd),
    .in_rs_data    (in_rs_data),
    .in_rt_data    (in_rt_data),
    .in_imm        (in_imm),
    .flush         (flush),
    .wb_result     (wb_result),
    .wb_rd         (wb_rd),
    .wb_en         (wb_en),
    .inflight_mask (inflight_mask)
`ifdef EXECUTE_STATUS_FLAGS_EN
    ,
    .flags         (flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          age;
    logic        wr;
    logic [3:0]  rd;
    logic [31:0] res;
    logic [3:0]  fl;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_res = '0;
  logic [3:0]  m_rd  = '0;
  logic        m_en  = 1'b0;
  logic [3:0]  m_fl  = '0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // add/sub with flags from wide signed/unsigned arithmetic
  task automatic arith(input logic [31:0] a, input logic [31:0] b, input bit sub,
                       output logic [31:0] r, output logic c, output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r = a - b;
      c = (a >= b);
      s = sa - sb;
    end else begin
      r = a + b;
      c = ({32'h0, a} + {32'h0, b}) >= 64'h1_0000_0000;
      s = sa + sb;
    end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  task automatic ref_exec(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, output logic [31:0] r, output logic [3:0] fl);
    logic [31:0] se, ze;
    logic [63:0] p;
    logic c, v;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0, imm};
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (op)
      4'h1: arith(rs, se, 1'b0, r, c, v);
      4'h2: arith(rs, se, 1'b1, r, c, v);
      4'h3: r = se;
      4'h4: r = rs & ze;
      4'h5: r = rs | ze;
      4'h6: r = rs ^ ze;
      4'h7: r = ~rs;
      4'h8: arith(rs, rt, 1'b0, r, c, v);
      4'h9: r = rs << imm[4:0];
      4'hA: arith(rs, rt, 1'b1, r, c, v);
      4'hB: r = rs >> imm[4:0];
      4'hC: r = 32'($signed(rs) >>> imm[4:0]);
      4'hD: r = rs & rt;
      4'hE: r = rs | rt;
      4'hF: begin p = {32'h0, rs} * {32'h0, rt}; r = p[31:0]; end
      default: r = '0;
    endcase
    fl = {r == 32'h0, r[31], c, v};
  endtask

  task automatic check_outputs(input string pfx);
    logic [15:0] mk;
    mk = '0;
    foreach (q[i]) if (q[i].wr) mk[q[i].rd] = 1'b1;
    chk({pfx, ":wb_en"},  {31'h0, wb_en}, {31'h0, m_en});
    chk({pfx, ":wb_rd"},  {28'h0, wb_rd}, {28'h0, m_rd});
    chk({pfx, ":wb_res"}, wb_result, m_res);
    chk({pfx, ":mask"},   {16'h0, inflight_mask}, {16'h0, mk});
`ifdef EXECUTE_STATUS_FLAGS_EN
    chk({pfx, ":flags"},  {28'h0, flags}, {28'h0, m_fl});
`endif
  endtask

  // Drive one cycle of input (called just after a negedge), advance the model
  // at the posedge and compare at the following negedge.
  task automatic step(input string tag, input logic v, input logic [3:0] op, input logic [3:0] rd,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic fl);
    ent_t e;
    in_valid = v; in_opcode = op; in_rd = rd;
    in_rs_data = rs; in_rt_data = rt; in_imm = imm; flush = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_en = 1'b0;
    end else begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age > 3) void'(q.pop_front());
      m_en = 1'b0;
      if (q.size() > 0 && q[0].age == 3 && q[0].wr) begin
        m_en = 1'b1;
        m_rd = q[0].rd;
        m_res = q[0].res;
        m_fl = q[0].fl;
      end
      if (v) begin
        e.age = 1;
        e.rd = rd;
        e.wr = (op != 4'h0) && (rd != 4'h0);
        ref_exec(op, rs, rt, imm, e.res, e.fl);
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic bubble(input string tag);
    step(tag, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 16'h0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // ADDI 5 + sext(FFFE) = 3
    step("addi", 1'b1, 4'h1, 4'd3, 32'h5, 32'h0, 16'hFFFE, 1'b0);
    chk("addi_mask1", {16'h0, inflight_mask}, 32'h0000_0008);
    bubble("addi_d1");
    bubble("addi_d2");
    chk("addi_wb", wb_result, 32'h0000_0003);
    bubble("addi_d3");

    // back-to-back
    step("b2b_add", 1'b1, 4'h8, 4'd1, 32'd7, 32'd8, 16'h0, 1'b0);
    step("b2b_sub", 1'b1, 4'hA, 4'd2, 32'd7, 32'd8, 16'h0, 1'b0);
    step("b2b_li",  1'b1, 4'h3, 4'd4, 32'h0, 32'h0, 16'h8000, 1'b0);
    chk("b2b_add_wb", wb_result, 32'h0000_000F);
    bubble("b2b_d1");
    chk("b2b_sub_wb", wb_result, 32'hFFFF_FFFF);
    bubble("b2b_d2");
    chk("b2b_li_wb", wb_result, 32'hFFFF_8000);
    bubble("b2b_d3");

    // R0 target and NOP
    step("r0_add", 1'b1, 4'h8, 4'd0, 32'd1, 32'd2, 16'h0, 1'b0);
    step("nop_rd5", 1'b1, 4'h0, 4'd5, 32'd1, 32'd2, 16'h0, 1'b0);
    repeat (3) bubble("r0_drain");

    // flush one cycle after a MUL, then the same MUL unflushed
    step("mul_fl", 1'b1, 4'hF, 4'd6, 32'h10000, 32'h10000, 16'h0, 1'b0);
    step("flush", 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 16'h0, 1'b1);
    chk("flush_mask", {16'h0, inflight_mask}, 32'h0);
    repeat (3) bubble("flush_drain");
    step("mul", 1'b1, 4'hF, 4'd6, 32'h10000, 32'h10000, 16'h0, 1'b0);
    bubble("mul_d1");
    bubble("mul_d2");
    chk("mul_en", {31'h0, wb_en}, 32'h1);
    chk("mul_wb", wb_result, 32'h0);

    // flush with same-cycle valid issue: flush wins
    step("fl_issue", 1'b1, 4'h3, 4'd7, 32'h0, 32'h0, 16'h1234, 1'b1);
    repeat (3) bubble("fl_issue_drain");

    // shifts
    step("srai", 1'b1, 4'hC, 4'd8, 32'h8000_0000, 32'h0, 16'd4, 1'b0);
    step("srli", 1'b1, 4'hB, 4'd9, 32'h8000_0000, 32'h0, 16'd4, 1'b0);
    bubble("sh_d1");
    chk("srai_wb", wb_result, 32'hF800_0000);
    bubble("sh_d2");
    chk("srli_wb", wb_result, 32'h0800_0000);
    bubble("sh_d3");

    // async reset with 3 in flight
    step("ar_1", 1'b1, 4'h8, 4'd1, 32'd1, 32'd2, 16'h0, 1'b0);
    step("ar_2", 1'b1, 4'h8, 4'd2, 32'd3, 32'd4, 16'h0, 1'b0);
    step("ar_3", 1'b1, 4'h8, 4'd3, 32'd5, 32'd6, 16'h0, 1'b0);
    rst = 1'b1;
    #1;
    q.delete();
    m_en = 1'b0; m_res = '0; m_rd = '0; m_fl = '0;
    check_outputs("async_rst");
    #1 rst = 1'b0;
    repeat (3) bubble("ar_drain");

    // signed overflow case: 0x7FFFFFFF + 1
    step("ovf", 1'b1, 4'h8, 4'd1, 32'h7FFF_FFFF, 32'h1, 16'h0, 1'b0);
    bubble("ovf_d1");
    bubble("ovf_d2");
    chk("ovf_wb", wb_result, 32'h8000_0000);
`ifdef EXECUTE_STATUS_FLAGS_EN
    chk("ovf_flags", {28'h0, flags}, 32'h5);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] imm;
      imm = $urandom();
      if ($urandom_range(3) == 0) imm = 16'($urandom_range(31));
      step("rnd", ($urandom_range(3) != 0), 4'($urandom_range(15)),
           4'($urandom_range(15)), $urandom(), $urandom(), imm,
           ($urandom_range(15) == 0));
    end
    repeat (3) bubble("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
